instr_decode_seq: RTL and testbench
===================================

// Module: instr_decode_seq
// PURPOSE
//  Registered, parametrised decoder and register-port sequencer for the 16-bit ISA.
//  Accepts one instruction per valid/ready handshake and latches the decoded fields.
//  Drives the register-file read and write selects one step per cycle (Rn, Rm, Rd)
//  according to the opcode, replacing the controller's manual nsel steering.
//  Sits between the instruction register and the datapath/register file.
// PARAMETERS
//  DATA_W        16  width of sximm5/sximm8 outputs; legal range >= 8
//  ILLEGAL_HOLD  0   0: illegal opcode gives a 1-cycle illegal+done pulse; 1: sticky ILLEGAL until reset
// PORTS
//  clk          in   1       single clock, all state on posedge
//  reset_n      in   1       synchronous, active-low reset
//  in_valid     in   1       instruction valid
//  in_ready     out  1       high only in IDLE (and never in ILLEGAL)
//  instruction  in   16      [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm
//  stall        in   1       hold current step; outputs stay stable
//  opcode       out  3       latched instruction[15:13]
//  op           out  2       latched instruction[12:11]
//  alu_op       out  2       latched instruction[12:11]
//  shift        out  2       latched [4:3] for opcode 101 and for 110/op00; 2'b00 otherwise
//  sximm5       out  DATA_W  sign-extended latched [4:0]
//  sximm8       out  DATA_W  sign-extended latched [7:0]
//  rd_en        out  1       register read-port select valid this cycle
//  rd_num       out  3       register index to read
//  wr_en        out  1       register write enable this cycle
//  wr_num       out  3       register index to write
//  busy         out  1       state != IDLE
//  done         out  1       1-cycle pulse on final step
//  illegal      out  1       unsupported opcode/op seen
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge, any state incl. mid-sequence): state=IDLE; all outputs 0 except in_ready=1.
//  - Accept: in_valid & in_ready at posedge k -> fields latched; first step visible in cycle k+1.
//  - States: IDLE, S_RDN, S_RDM, S_WR, ILLEGAL. Each step lasts 1 cycle unless stall=1.
//  - Sequences by {opcode,op}:
//    101/00 ADD and 101/10 AND: S_RDN(rd=Rn) -> S_RDM(rd=Rm) -> S_WR(wr=Rd).
//    101/01 CMP: S_RDN -> S_RDM; done on S_RDM; no write.
//    101/11 MVN: S_RDM -> S_WR(wr=Rd).
//    110/10 MOV imm: S_WR(wr=Rn) only.
//    110/00 MOV reg: S_RDM -> S_WR(wr=Rd).
//    Any other code -> ILLEGAL.
//  - rd_en=1 exactly in S_RDN and S_RDM. wr_en=1 exactly in S_WR.
//  - rd_num/wr_num are 0 when the corresponding enable is 0.
//  - done=1 in the last step of a sequence (not held while stalled).
//  - The state after the last step is IDLE; the next accept is possible the following cycle.
//  - stall=1: state, latched fields and enables hold; done is suppressed until the stall releases.
//  - stall while IDLE: no effect, and an accept still happens.
//  - ILLEGAL, ILLEGAL_HOLD=0: illegal=1 and done=1 for one cycle, then IDLE.
//  - ILLEGAL, ILLEGAL_HOLD=1: illegal=1 is held and in_ready=0 until reset.
//  - Sign extension: sximm5 = {{(DATA_W-5){i[4]}}, i[4:0]}; sximm8 = {{(DATA_W-8){i[7]}}, i[7:0]}.
//  - in_valid is ignored when in_ready=0; the instruction input is not sampled outside accept.
// STRUCTURE
//  - Package instr_pkg holds:
//    opcode/op localparams (OPC_ALU=3'b101, OPC_MOV=3'b110, ALU_ADD/CMP/AND/MVN, MOV_IMM/MOV_REG);
//    the state encoding; the field bit positions.
//  - One sub-module: sext_field #(IN_W, OUT_W), instanced twice for sximm5 and sximm8.
//  - Next-state logic is a single case on state, using the latched {opcode,op}.
// TESTING
//  - ADD 16'hA1A2 (Rn=1, Rd=5, Rm=2), accepted at cycle 0:
//    c1 rd_en/rd_num=1; c2 rd_num=2; c3 wr_en/wr_num=5 with done=1; c4 in_ready=1.
//  - MOV imm 16'hD3F0 (Rn=3, imm8=F0), DATA_W=16:
//    c1 wr_en=1, wr_num=3, done=1; sximm8=16'hFFF0; shift=0.
//  - CMP 16'hA9E1 (Rn=1, Rm=1) with stall=1 during c2..c4:
//    S_RDM held 3 extra cycles; done=1 only in c5; wr_en never asserted.
//  - Opcode 3'b111 with ILLEGAL_HOLD=0: illegal=1, done=1 in c1, IDLE in c2.
//    Same with ILLEGAL_HOLD=1: in_ready stays 0 until reset_n=0.
//  - reset_n=0 asserted during S_RDM of an ADD:
//    next cycle rd_en=wr_en=done=busy=0 and in_ready=1; no write issued.
//  - Back-to-back accepts with in_valid held at 1:
//    the second instruction is accepted in the cycle after done, and the first sequence's fields are unchanged until then.

Source files
------------

// File: rtl/instr_decode_seq_pkg.sv
// Shared definitions for the 16-bit ISA decoder/sequencer: opcode and op
// codes, instruction field positions, the sequencer state encoding, and the
// helper that maps a decoded {opcode,op} to its first sequencer step.
package instr_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  // Field positions within the instruction word (LSB of each field)
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM5_W  = 5;
  localparam int IMM8_W  = 8;

  // state    | meaning
  // IDLE     | waiting for an instruction, in_ready=1
  // S_RDN    | read port selects Rn
  // S_RDM    | read port selects Rm
  // S_WR     | write port selects Rd (Rn for MOV imm)
  // ILLEGAL  | unsupported {opcode,op} latched
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_RDN   = 3'd1,
    S_RDM   = 3'd2,
    S_WR    = 3'd3,
    ILLEGAL = 3'd4
  } state_t;

  function automatic state_t first_step(input logic [2:0] opc, input logic [1:0] op);
    state_t s;
    s = ILLEGAL;
    if (opc == OPC_ALU) begin
      if (op == ALU_MVN) s = S_RDM;
      else               s = S_RDN;
    end else if (opc == OPC_MOV) begin
      if (op == MOV_IMM)      s = S_WR;
      else if (op == MOV_REG) s = S_RDM;
    end
    return s;
  endfunction

endpackage

// File: rtl/instr_decode_seq_if.sv
// Instruction handshake between the instruction register (master) and the
// decoder/sequencer (slave).
interface instr_decode_seq_if;
  logic                            in_valid;
  logic                            in_ready;
  logic [instr_pkg::INSTR_W-1:0]   instruction;

  modport master (output in_valid, output instruction, input in_ready);
  modport slave  (input in_valid, input instruction, output in_ready);
endinterface

// File: rtl/instr_decode_seq_sext_field.sv
// Sign extension of an IN_W-bit immediate field to OUT_W bits (OUT_W >= IN_W).
module sext_field #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  if (OUT_W > IN_W) begin : g_ext
    assign out_o = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};
  end else begin : g_same
    assign out_o = in_i[OUT_W-1:0];
  end

endmodule

// File: rtl/instr_decode_seq.sv
// Registered decoder and register-port sequencer. Latches one instruction per
// handshake, then steps the register-file read/write selects (Rn, Rm, Rd)
// one cycle per step according to {opcode,op}. done is the registered
// last-step flag gated by stall, so it only shows in the cycle the step completes.
module instr_decode_seq
  import instr_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter bit ILLEGAL_HOLD = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  instr_decode_seq_if.slave  bus,
  output logic [2:0]         opcode,
  output logic [1:0]         op,
  output logic [1:0]         alu_op,
  output logic [1:0]         shift,
  output logic [DATA_W-1:0]  sximm5,
  output logic [DATA_W-1:0]  sximm8,
  output logic               rd_en,
  output logic [2:0]         rd_num,
  output logic               wr_en,
  output logic [2:0]         wr_num,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  state_t      state_q, state_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  shift_q, shift_d;
  logic [2:0]  rn_q, rn_d, rd_q, rd_d, rm_q, rm_d;
  logic [7:0]  imm8_q, imm8_d;

  logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [2:0]  rd_num_q, rd_num_d, wr_num_q, wr_num_d;
  logic        last_q, last_d, illegal_q, illegal_d;
  logic        busy_q, busy_d, in_ready_q, in_ready_d;

  // Next state, field latching on accept, and the registered outputs for the next step
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    shift_d  = shift_q;
    rn_d     = rn_q;
    rd_d     = rd_q;
    rm_d     = rm_q;
    imm8_d   = imm8_q;

    case (state_q)
      IDLE: if (bus.in_valid) begin
        opcode_d = bus.instruction[OPC_LSB +: 3];
        op_d     = bus.instruction[OP_LSB +: 2];
        rn_d     = bus.instruction[RN_LSB +: 3];
        rd_d     = bus.instruction[RD_LSB +: 3];
        rm_d     = bus.instruction[RM_LSB +: 3];
        imm8_d   = bus.instruction[IMM8_W-1:0];
        shift_d  = ((opcode_d == OPC_ALU) || (opcode_d == OPC_MOV && op_d == MOV_REG))
                   ? bus.instruction[SH_LSB +: 2] : 2'b00;
        state_d  = first_step(opcode_d, op_d);
      end
      S_RDN:   if (!stall) state_d = S_RDM;
      S_RDM:   if (!stall) state_d = (opcode_q == OPC_ALU && op_q == ALU_CMP) ? IDLE : S_WR;
      S_WR:    if (!stall) state_d = IDLE;
      ILLEGAL: if (!stall && !ILLEGAL_HOLD) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d    = (state_d == S_RDN) || (state_d == S_RDM);
    rd_num_d   = (state_d == S_RDN) ? rn_d : (state_d == S_RDM) ? rm_d : 3'b000;
    wr_en_d    = (state_d == S_WR);
    wr_num_d   = !wr_en_d ? 3'b000 :
                 (opcode_d == OPC_MOV && op_d == MOV_IMM) ? rn_d : rd_d;
    last_d     = (state_d == S_WR) ||
                 (state_d == S_RDM && opcode_d == OPC_ALU && op_d == ALU_CMP) ||
                 (state_d == ILLEGAL && !ILLEGAL_HOLD);
    illegal_d  = (state_d == ILLEGAL);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // Sequencer state, latched fields and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      opcode_q   <= 3'b000;
      op_q       <= 2'b00;
      shift_q    <= 2'b00;
      rn_q       <= 3'b000;
      rd_q       <= 3'b000;
      rm_q       <= 3'b000;
      imm8_q     <= 8'h00;
      rd_en_q    <= 1'b0;
      rd_num_q   <= 3'b000;
      wr_en_q    <= 1'b0;
      wr_num_q   <= 3'b000;
      last_q     <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
      rn_q       <= rn_d;
      rd_q       <= rd_d;
      rm_q       <= rm_d;
      imm8_q     <= imm8_d;
      rd_en_q    <= rd_en_d;
      rd_num_q   <= rd_num_d;
      wr_en_q    <= wr_en_d;
      wr_num_q   <= wr_num_d;
      last_q     <= last_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  sext_field #(.IN_W(IMM5_W), .OUT_W(DATA_W)) u_sext5 (
    .in_i  (imm8_q[IMM5_W-1:0]),
    .out_o (sximm5)
  );

  sext_field #(.IN_W(IMM8_W), .OUT_W(DATA_W)) u_sext8 (
    .in_i  (imm8_q),
    .out_o (sximm8)
  );

  assign bus.in_ready = in_ready_q;
  assign opcode       = opcode_q;
  assign op           = op_q;
  assign alu_op       = op_q;
  assign shift        = shift_q;
  assign rd_en        = rd_en_q;
  assign rd_num       = rd_num_q;
  assign wr_en        = wr_en_q;
  assign wr_num       = wr_num_q;
  assign busy         = busy_q;
  assign illegal      = illegal_q;
  assign done         = last_q & ~stall;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Bench for instr_decode_seq: directed timing scenarios plus randomized
// instructions with random stalls, checked by a scoreboard of expected steps.
module tb_instr_decode_seq;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic dir_stall = 1'b0;
  logic rnd_stall = 1'b0;
  logic rand_stall_en = 1'b0;
  logic stall;
  logic stall1 = 1'b0;
  assign stall = rand_stall_en ? rnd_stall : dir_stall;

  instr_decode_seq_if bus0 ();
  instr_decode_seq_if bus1 ();

  logic [2:0] opcode0, rd_num0, wr_num0;
  logic [1:0] op0, alu_op0, shift0;
  logic [DW-1:0] sximm5_0, sximm8_0;
  logic rd_en0, wr_en0, busy0, done0, illegal0;

  logic [2:0] opcode1, rd_num1, wr_num1;
  logic [1:0] op1, alu_op1, shift1;
  logic [DW-1:0] sximm5_1, sximm8_1;
  logic rd_en1, wr_en1, busy1, done1, illegal1;

  instr_decode_seq #(.DATA_W(DW), .ILLEGAL_HOLD(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .bus(bus0),
    .opcode(opcode0), .op(op0), .alu_op(alu_op0), .shift(shift0),
    .sximm5(sximm5_0), .sximm8(sximm8_0),
    .rd_en(rd_en0), .rd_num(rd_num0), .wr_en(wr_en0), .wr_num(wr_num0),
    .busy(busy0), .done(done0), .illegal(illegal0)
  );

  instr_decode_seq #(.DATA_W(DW), .ILLEGAL_HOLD(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall1), .bus(bus1),
    .opcode(opcode1), .op(op1), .alu_op(alu_op1), .shift(shift1),
    .sximm5(sximm5_1), .sximm8(sximm8_1),
    .rd_en(rd_en1), .rd_num(rd_num1), .wr_en(wr_en1), .wr_num(wr_num1),
    .busy(busy1), .done(done1), .illegal(illegal1)
  );

  typedef struct {
    logic          rd_en;
    logic [2:0]    rd_num;
    logic          wr_en;
    logic [2:0]    wr_num;
    logic          done;
    logic          illegal;
    logic [2:0]    opc;
    logic [1:0]    op;
    logic [1:0]    sh;
    logic [DW-1:0] sx5;
    logic [DW-1:0] sx8;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  logic [4:0] codes [6] = '{5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11010, 5'b11000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list the register-port steps an instruction must produce
  task automatic push_model(input logic [15:0] ins);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    int v5, v8;
    int kind[$];
    int num[$];
    exp_t b;
    opc = ins[15:13]; op = ins[12:11];
    rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0];
    v5 = int'(ins[4:0]); if (v5 >= 16)  v5 -= 32;
    v8 = int'(ins[7:0]); if (v8 >= 128) v8 -= 256;
    b.opc = opc; b.op = op;
    b.sh  = (opc == 3'b101 || (opc == 3'b110 && op == 2'b00)) ? ins[4:3] : 2'b00;
    b.sx5 = v5[DW-1:0];
    b.sx8 = v8[DW-1:0];
    if      (opc == 3'b101 && (op == 2'b00 || op == 2'b10)) begin kind = '{0, 0, 1}; num = '{int'(rn), int'(rm), int'(rd)}; end
    else if (opc == 3'b101 && op == 2'b01) begin kind = '{0, 0}; num = '{int'(rn), int'(rm)}; end
    else if (opc == 3'b101 && op == 2'b11) begin kind = '{0, 1}; num = '{int'(rm), int'(rd)}; end
    else if (opc == 3'b110 && op == 2'b10) begin kind = '{1};    num = '{int'(rn)}; end
    else if (opc == 3'b110 && op == 2'b00) begin kind = '{0, 1}; num = '{int'(rm), int'(rd)}; end
    else begin kind = '{2}; num = '{0}; end
    for (int i = 0; i < kind.size(); i++) begin
      b.rd_en   = (kind[i] == 0);
      b.wr_en   = (kind[i] == 1);
      b.illegal = (kind[i] == 2);
      b.rd_num  = (kind[i] == 0) ? num[i][2:0] : 3'b000;
      b.wr_num  = (kind[i] == 1) ? num[i][2:0] : 3'b000;
      b.done    = (i == kind.size() - 1);
      sbq.push_back(b);
    end
  endtask

  // Monitor: every completed (non-stalled) step is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if ((rd_en0 | wr_en0 | illegal0) && !stall) begin
          if (sbq.size() == 0) begin
            chk("unexpected_step", 32'({rd_en0, wr_en0, illegal0}), 0);
          end else begin
            mon_e = sbq.pop_front();
            chk("rd_en",   32'(rd_en0),   32'(mon_e.rd_en));
            chk("rd_num",  32'(rd_num0),  32'(mon_e.rd_num));
            chk("wr_en",   32'(wr_en0),   32'(mon_e.wr_en));
            chk("wr_num",  32'(wr_num0),  32'(mon_e.wr_num));
            chk("done",    32'(done0),    32'(mon_e.done));
            chk("illegal", 32'(illegal0), 32'(mon_e.illegal));
            chk("opcode",  32'(opcode0),  32'(mon_e.opc));
            chk("op",      32'(op0),      32'(mon_e.op));
            chk("alu_op",  32'(alu_op0),  32'(mon_e.op));
            chk("shift",   32'(shift0),   32'(mon_e.sh));
            chk("sximm5",  32'(sximm5_0), 32'(mon_e.sx5));
            chk("sximm8",  32'(sximm8_0), 32'(mon_e.sx8));
            chk("busy",    32'(busy0),    1);
          end
        end else begin
          chk("done_quiet", 32'(done0), 0);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rnd_stall = ($urandom_range(0, 3) == 0);
    end
  end

  // Present an instruction on bus0 (called at posedge+1) until accepted, then log expectations
  task automatic send0(input logic [15:0] ins, input bit keep, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus0.instruction = ins;
    bus0.in_valid = 1'b1;
    while (!acc && waited < 64) begin
      @(negedge clk);
      acc = bus0.in_ready;
      @(posedge clk); #1;
      waited++;
    end
    chk("accept_timeout", 32'(acc), 1);
    if (acc) push_model(ins);
    if (!keep) bus0.in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    @(negedge clk);
  endtask

  initial begin
    int w, k, gap, t;
    logic [15:0] ins;
    reset_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.instruction = 16'h0000;
    bus1.in_valid = 1'b0; bus1.instruction = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus0.in_ready), 1);
    chk("rst_busy",     32'(busy0),  0);
    chk("rst_rd_en",    32'(rd_en0), 0);
    chk("rst_wr_en",    32'(wr_en0), 0);
    chk("rst_done",     32'(done0),  0);
    chk("rst_illegal",  32'(illegal0), 0);
    chk("rst_sximm8",   32'(sximm8_0), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD R5 = R1 + R2
    send0(16'hA1A2, 0, w);
    @(negedge clk);
    chk("add_c1_rd_en",  32'(rd_en0), 1);
    chk("add_c1_rd_num", 32'(rd_num0), 1);
    chk("add_c1_done",   32'(done0), 0);
    step();
    chk("add_c2_rd_num", 32'(rd_num0), 2);
    step();
    chk("add_c3_wr_en",  32'(wr_en0), 1);
    chk("add_c3_wr_num", 32'(wr_num0), 5);
    chk("add_c3_done",   32'(done0), 1);
    step();
    chk("add_c4_ready",  32'(bus0.in_ready), 1);
    chk("add_c4_busy",   32'(busy0), 0);
    @(posedge clk); #1;

    // MOV R3, #-16
    send0(16'hD3F0, 0, w);
    @(negedge clk);
    chk("movi_wr_en",  32'(wr_en0), 1);
    chk("movi_wr_num", 32'(wr_num0), 3);
    chk("movi_done",   32'(done0), 1);
    chk("movi_sximm8", 32'(sximm8_0), 'hFFF0);
    chk("movi_shift",  32'(shift0), 0);
    @(posedge clk); #1;

    // CMP R1, R1 with the Rm step stalled for three cycles
    send0(16'hA9E1, 0, w);
    @(negedge clk);
    chk("cmp_c1_rd_num", 32'(rd_num0), 1);
    @(posedge clk); #1;
    dir_stall = 1'b1;
    @(negedge clk);
    chk("cmp_c2_rd_en", 32'(rd_en0), 1);
    chk("cmp_c2_done",  32'(done0), 0);
    step();
    chk("cmp_c3_done",  32'(done0), 0);
    chk("cmp_c3_rd_en", 32'(rd_en0), 1);
    step();
    chk("cmp_c4_done",  32'(done0), 0);
    chk("cmp_c4_wr_en", 32'(wr_en0), 0);
    @(posedge clk); #1;
    dir_stall = 1'b0;
    @(negedge clk);
    chk("cmp_c5_done",  32'(done0), 1);
    chk("cmp_c5_rd_en", 32'(rd_en0), 1);
    chk("cmp_c5_wr_en", 32'(wr_en0), 0);
    step();
    chk("cmp_c6_busy",  32'(busy0), 0);
    chk("cmp_c6_wr_en", 32'(wr_en0), 0);
    @(posedge clk); #1;

    // Illegal opcode, pulse mode
    send0(16'hE000, 0, w);
    @(negedge clk);
    chk("ill_c1_illegal", 32'(illegal0), 1);
    chk("ill_c1_done",    32'(done0), 1);
    chk("ill_c1_ready",   32'(bus0.in_ready), 0);
    step();
    chk("ill_c2_illegal", 32'(illegal0), 0);
    chk("ill_c2_ready",   32'(bus0.in_ready), 1);
    @(posedge clk); #1;

    // Illegal opcode, sticky mode: further valid instructions are ignored until reset
    bus1.instruction = 16'hE000;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.instruction = 16'hA1A2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_illegal", 32'(illegal1), 1);
      chk("hold_ready",   32'(bus1.in_ready), 0);
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("hold_rst_ready",   32'(bus1.in_ready), 1);
    chk("hold_rst_illegal", 32'(illegal1), 0);
    @(posedge clk); #1;

    // Reset while an ADD sits in its Rm step: no write may follow
    send0(16'hA1A2, 0, w);
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("mrst_rd_en", 32'(rd_en0), 0);
    chk("mrst_wr_en", 32'(wr_en0), 0);
    chk("mrst_done",  32'(done0), 0);
    chk("mrst_busy",  32'(busy0), 0);
    chk("mrst_ready", 32'(bus0.in_ready), 1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mrst_no_write", 32'(wr_en0), 0);
    end
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    send0(16'hA1A2, 1, w);
    bus0.instruction = 16'hD3F0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("b2b_ready",  32'(bus0.in_ready), 32'(c == 4));
      chk("b2b_opcode", 32'(opcode0), 'h5);
      @(posedge clk); #1;
    end
    push_model(16'hD3F0);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_wr_en",  32'(wr_en0), 1);
    chk("b2b_second_wr_num", 32'(wr_num0), 3);
    @(posedge clk); #1;

    // Randomized instructions with random stalls
    rand_stall_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 7);
      ins = 16'($urandom);
      if (k < 6) ins[15:11] = codes[k];
      send0(ins, 0, w);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    rand_stall_en = 1'b0;
    chk("drain", 32'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
